// File: rtl/cnn_pkg.sv
// Shared defaults and types for the CNN line-buffer blocks.
package cnn_pkg;

  localparam int CNN_DATA_WIDTH   = 17;
  localparam int CNN_IMAGE_WIDTH  = 28;
  localparam int CNN_KERNEL_WIDTH = 5;

  // FILL: the line is still collecting its first DEPTH samples.
  // RUN : the line is full; every accept evicts the oldest sample.
  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } line_state_e;

endpackage

// File: rtl/delay_ram.sv
// Single-address delay storage: one write and one asynchronous read that share
// an address, so a read in the same cycle as a write returns the old entry.
// Storage carries no reset so it can map onto distributed RAM.
module delay_ram #(
  parameter  int WIDTH = 17,
  parameter  int DEPTH = 23,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wrEn_i,
  input  logic [AW-1:0]    addr_i,
  input  logic [WIDTH-1:0] wrData_i,
  output logic [WIDTH-1:0] rdData_o
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write the new sample into the slot currently addressed.
  always_ff @(posedge clk) begin
    if (wrEn_i) begin
      mem[addr_i] <= wrData_i;
    end
  end

  assign rdData_o = mem[addr_i];

endmodule

// File: rtl/line_delay.sv
// Row delay line for a sliding-window convolution: every accepted sample comes
// back out DEPTH accepts later. Idle cycles never advance the line.
module line_delay
  import cnn_pkg::*;
#(
  parameter  int DATA_WIDTH   = CNN_DATA_WIDTH,
  parameter  int IMAGE_WIDTH  = CNN_IMAGE_WIDTH,
  parameter  int KERNEL_WIDTH = CNN_KERNEL_WIDTH,
  localparam int DEPTH        = IMAGE_WIDTH - KERNEL_WIDTH,
  localparam int FILL_W       = $clog2(DEPTH + 1)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clear,
  input  logic                         in_valid,
  input  logic signed [DATA_WIDTH-1:0] data_in,
  output logic                         out_valid,
  output logic signed [DATA_WIDTH-1:0] data_out,
  output logic                         primed,
  output logic        [FILL_W-1:0]     fill_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(DEPTH - 1);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(DEPTH - 1);

  if (DEPTH < 2 || DEPTH > 1023) begin : g_depth_check
    $error("line_delay: DEPTH = IMAGE_WIDTH - KERNEL_WIDTH must lie in 2..1023");
  end

  line_state_e             state_q, state_d;
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [FILL_W-1:0]       fill_count_q, fill_count_d;
  logic                    out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0]   data_out_q, data_out_d;

  logic                    ramWrEn;
  logic [DATA_WIDTH-1:0]   ramRdData;

  delay_ram #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (DEPTH)
  ) u_delay_ram (
    .clk      (clk),
    .wrEn_i   (ramWrEn),
    .addr_i   (wr_ptr_q),
    .wrData_i (data_in),
    .rdData_o (ramRdData)
  );

  // Control registers; reset empties the line and zeroes the output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= FILL;
      wr_ptr_q     <= '0;
      fill_count_q <= '0;
      out_valid_q  <= 1'b0;
      data_out_q   <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      fill_count_q <= fill_count_d;
      out_valid_q  <= out_valid_d;
      data_out_q   <= data_out_d;
    end
  end

  // Next state: clear beats a same-cycle accept, and only RUN accepts emit.
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    fill_count_d = fill_count_q;
    out_valid_d  = 1'b0;
    data_out_d   = data_out_q;
    ramWrEn      = 1'b0;

    if (clear) begin
      state_d      = FILL;
      wr_ptr_d     = '0;
      fill_count_d = '0;
    end else if (in_valid) begin
      ramWrEn  = 1'b1;
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
      case (state_q)
        FILL: begin
          fill_count_d = fill_count_q + FILL_W'(1);
          if (fill_count_q == FILL_LAST) begin
            state_d = RUN;
          end
        end
        RUN: begin
          out_valid_d = 1'b1;
          data_out_d  = ramRdData;
        end
        default: begin
          state_d = FILL;
        end
      endcase
    end
  end

  assign out_valid  = out_valid_q;
  assign data_out   = data_out_q;
  assign primed     = (state_q == RUN);
  assign fill_count = fill_count_q;

endmodule

// File: tb/tb_line_delay.sv
// Bench for line_delay: a default-size instance (DEPTH 23) and a narrow
// instance (DEPTH 7) checked against a queue-based model of the delay line.
module tb_line_delay;

  localparam int DWA     = 17;
  localparam int DEPTH_A = 23;
  localparam int FWA     = 5;
  localparam int DWB     = 8;
  localparam int DEPTH_B = 7;
  localparam int FWB     = 3;

  logic clk;
  logic reset;

  logic                  clearA, validA;
  logic signed [DWA-1:0] dataA;
  logic                  outValidA, primedA;
  logic signed [DWA-1:0] dataOutA;
  logic [FWA-1:0]        fillA;

  logic                  clearB, validB;
  logic signed [DWB-1:0] dataB;
  logic                  outValidB, primedB;
  logic signed [DWB-1:0] dataOutB;
  logic [FWB-1:0]        fillB;

  int errors = 0;
  int checks = 0;
  int stepNo = 0;

  line_delay dutA (
    .clk        (clk),
    .reset      (reset),
    .clear      (clearA),
    .in_valid   (validA),
    .data_in    (dataA),
    .out_valid  (outValidA),
    .data_out   (dataOutA),
    .primed     (primedA),
    .fill_count (fillA)
  );

  line_delay #(
    .DATA_WIDTH   (8),
    .IMAGE_WIDTH  (10),
    .KERNEL_WIDTH (3)
  ) dutB (
    .clk        (clk),
    .reset      (reset),
    .clear      (clearB),
    .in_valid   (validB),
    .data_in    (dataB),
    .out_valid  (outValidB),
    .data_out   (dataOutB),
    .primed     (primedB),
    .fill_count (fillB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a FIFO of samples accepted since the last reset/clear.
  logic signed [DWA-1:0] qA[$];
  logic                  expValidA = 1'b0;
  logic signed [DWA-1:0] expOutA   = '0;
  logic signed [DWB-1:0] qB[$];
  logic                  expValidB = 1'b0;
  logic signed [DWB-1:0] expOutB   = '0;

  typedef struct {
    logic                  clr;
    logic                  vld;
    logic signed [DWA-1:0] din;
    logic                  expValid;
    logic signed [DWA-1:0] expOut;
    int                    expFill;
    logic                  expPrimed;
  } vec_t;

  vec_t vecs[60];

  task automatic checkValue(input string name, input longint actual, input longint expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic checkOutput();
    checkValue($sformatf("A out_valid @%0d", stepNo), longint'(outValidA), longint'(expValidA));
    checkValue($sformatf("A data_out @%0d", stepNo), longint'(dataOutA), longint'(expOutA));
    checkValue($sformatf("A fill_count @%0d", stepNo), longint'(fillA), longint'(qA.size()));
    checkValue($sformatf("A primed @%0d", stepNo), longint'(primedA), longint'(qA.size() == DEPTH_A));
  endtask

  task automatic checkOutputB();
    checkValue($sformatf("B out_valid @%0d", stepNo), longint'(outValidB), longint'(expValidB));
    checkValue($sformatf("B data_out @%0d", stepNo), longint'(dataOutB), longint'(expOutB));
    checkValue($sformatf("B fill_count @%0d", stepNo), longint'(fillB), longint'(qB.size()));
    checkValue($sformatf("B primed @%0d", stepNo), longint'(primedB), longint'(qB.size() == DEPTH_B));
  endtask

  task automatic applyStimulus(input logic c, input logic v, input logic signed [DWA-1:0] d);
    clearA = c;
    validA = v;
    dataA  = d;
    @(posedge clk);
    #1;
    clearA = 1'b0;
    validA = 1'b0;
    stepNo++;
    if (c) begin
      qA.delete();
      expValidA = 1'b0;
    end else if (v) begin
      expValidA = 1'b0;
      if (qA.size() == DEPTH_A) begin
        expOutA   = qA.pop_front();
        expValidA = 1'b1;
      end
      qA.push_back(d);
    end else begin
      expValidA = 1'b0;
    end
    checkOutput();
  endtask

  task automatic applyStimulusB(input logic c, input logic v, input logic signed [DWB-1:0] d);
    clearB = c;
    validB = v;
    dataB  = d;
    @(posedge clk);
    #1;
    clearB = 1'b0;
    validB = 1'b0;
    stepNo++;
    if (c) begin
      qB.delete();
      expValidB = 1'b0;
    end else if (v) begin
      expValidB = 1'b0;
      if (qB.size() == DEPTH_B) begin
        expOutB   = qB.pop_front();
        expValidB = 1'b1;
      end
      qB.push_back(d);
    end else begin
      expValidB = 1'b0;
    end
    checkOutputB();
  endtask

  initial begin
    logic signed [DWB-1:0] pat[3];
    logic [31:0]           r;
    logic                  v;
    int                    accepted;
    int                    guard;

    pat[0] = 8'h80;
    pat[1] = 8'h7F;
    pat[2] = 8'hFF;

    for (int k = 1; k <= 60; k++) begin
      vecs[k-1].clr       = 1'b0;
      vecs[k-1].vld       = 1'b1;
      vecs[k-1].din       = DWA'(k);
      vecs[k-1].expValid  = (k > DEPTH_A);
      vecs[k-1].expOut    = (k > DEPTH_A) ? DWA'(k - DEPTH_A) : '0;
      vecs[k-1].expFill   = (k < DEPTH_A) ? k : DEPTH_A;
      vecs[k-1].expPrimed = (k >= DEPTH_A);
    end

    reset  = 1'b0;
    clearA = 1'b0; validA = 1'b0; dataA = '0;
    clearB = 1'b0; validB = 1'b0; dataB = '0;
    #2 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    checkOutput();
    checkOutputB();

    // Fill with 1..23, then stream 24..60 back-to-back.
    for (int i = 0; i < 60; i++) begin
      applyStimulus(vecs[i].clr, vecs[i].vld, vecs[i].din);
      checkValue($sformatf("vec%0d out_valid", i), longint'(outValidA), longint'(vecs[i].expValid));
      checkValue($sformatf("vec%0d data_out", i), longint'(dataOutA), longint'(vecs[i].expOut));
      checkValue($sformatf("vec%0d fill_count", i), longint'(fillA), longint'(vecs[i].expFill));
      checkValue($sformatf("vec%0d primed", i), longint'(primedA), longint'(vecs[i].expPrimed));
    end

    // Random ~50% gaps over 200 accepted samples.
    accepted = 0;
    guard    = 0;
    while (accepted < 200 && guard < 2000) begin
      r = $urandom;
      v = 1'($urandom_range(0, 1));
      applyStimulus(1'b0, v, r[DWA-1:0]);
      if (v) accepted++;
      guard++;
    end
    checkValue("random accepts done", longint'(accepted), 200);

    // Clear with a same-cycle sample mid-RUN: the sample is dropped.
    applyStimulus(1'b1, 1'b1, 17'sd12345);
    checkValue("clear primed", longint'(primedA), 0);
    checkValue("clear fill", longint'(fillA), 0);
    for (int k = 0; k < DEPTH_A + 1; k++) begin
      applyStimulus(1'b0, 1'b1, DWA'(1000 + k));
    end
    checkValue("clear first out", longint'(dataOutA), 1000);
    checkValue("clear first valid", longint'(outValidA), 1);

    // Asynchronous reset pulse between edges while streaming.
    #3 reset = 1'b1;
    #1;
    checkValue("async data_out", longint'(dataOutA), 0);
    checkValue("async out_valid", longint'(outValidA), 0);
    checkValue("async primed", longint'(primedA), 0);
    checkValue("async fill", longint'(fillA), 0);
    #2 reset = 1'b0;
    qA.delete();
    expValidA = 1'b0;
    expOutA   = '0;
    qB.delete();
    expValidB = 1'b0;
    expOutB   = '0;
    for (int k = 1; k <= DEPTH_A + 1; k++) begin
      applyStimulus(1'b0, 1'b1, DWA'(k));
    end
    checkValue("refill first out", longint'(dataOutA), 1);

    // Narrow instance: -128, 127, -1 repeating across several pointer wraps.
    for (int k = 0; k < 30; k++) begin
      applyStimulusB(1'b0, 1'b1, pat[k % 3]);
      if (k == DEPTH_B) begin
        checkValue("B first out", longint'(dataOutB), -128);
      end
    end
    for (int k = 30; k < 60; k++) begin
      v = 1'($urandom_range(0, 1));
      applyStimulusB(1'b0, v, pat[k % 3]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/line_delay.md
LINE_DELAY -- requirements
Module: line_delay

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 17, meaning sample width in bits (two's complement).
REQ-002 SHALL have parameter IMAGE_WIDTH, default 28, meaning pixels per image row.
REQ-003 SHALL have parameter KERNEL_WIDTH, default 5, meaning convolution kernel width.
REQ-004 SHALL have derived localparam DEPTH = IMAGE_WIDTH - KERNEL_WIDTH, meaning delay in accepted samples; legal range 2..1023, with out-of-range rejected at elaboration.
REQ-005 SHALL have port clk, input, 1, meaning clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1, meaning reset: asynchronous, active-high.
REQ-007 SHALL have port clear, input, 1, meaning synchronous flush of the delay line.
REQ-008 SHALL have port in_valid, input, 1, meaning data_in carries a sample this cycle.
REQ-009 SHALL have port data_in, input, DATA_WIDTH signed, meaning input sample.
REQ-010 SHALL have port out_valid, output, 1, meaning data_out carries a delayed sample.
REQ-011 SHALL have port data_out, output, DATA_WIDTH signed, meaning sample accepted DEPTH accepts earlier.
REQ-012 SHALL have port primed, output, 1, meaning the line holds DEPTH samples.
REQ-013 SHALL have port fill_count, output, clog2(DEPTH+1), meaning samples currently held (0..DEPTH).

Function
REQ-014 SHALL store samples in a circular buffer of DEPTH entries with write pointer wr_ptr; shifting occurs only on accepted samples (in_valid=1), never on idle cycles.
REQ-015 SHALL wrap wr_ptr from DEPTH-1 to 0; non-power-of-two DEPTH SHALL wrap correctly.
REQ-016 SHALL implement two states: FILL (fill_count<DEPTH) and RUN (fill_count==DEPTH).
REQ-017 In FILL, each accept SHALL write data_in at wr_ptr, increment wr_ptr and fill_count; on the DEPTH-th accept the state SHALL move to RUN and primed SHALL assert the next cycle.
REQ-018 In RUN, each accept SHALL read the oldest entry at wr_ptr, overwrite it with data_in in the same cycle, and advance wr_ptr; fill_count SHALL hold at DEPTH.
REQ-019 Latency SHALL be one cycle: an accept in RUN at cycle t SHALL present the evicted sample on data_out with out_valid=1 at cycle t+1.
REQ-020 out_valid SHALL be 0 in any cycle not following a RUN-state accept; data_out SHALL hold its last value when out_valid=0.
REQ-021 Accepts during FILL SHALL NOT produce out_valid; no zero-padding samples are emitted.
REQ-022 Data SHALL pass bit-exact; no sign extension, rounding or arithmetic on samples.
REQ-023 clear=1 SHALL, at the next edge, set state FILL, wr_ptr=0, fill_count=0, primed=0, out_valid=0; data_out holds.
REQ-024 clear and in_valid in the same cycle: clear wins and the sample SHALL be dropped.
REQ-025 Buffer contents after clear/reset are don't-care and SHALL never reach data_out with out_valid=1.

Reset
REQ-026 reset=1 SHALL asynchronously force data_out=0, out_valid=0, primed=0, fill_count=0, wr_ptr=0, state FILL.
REQ-027 reset asserted mid-stream SHALL discard all held samples; first out_valid after release SHALL follow DEPTH new accepts.
REQ-028 Buffer storage SHALL NOT require reset (RAM-inferable).

Structure
REQ-029 Default DATA_WIDTH, IMAGE_WIDTH, KERNEL_WIDTH and the state enum SHALL live in shared package cnn_pkg.
REQ-030 Storage SHALL be sub-module delay_ram (1 write, 1 read, same-address read-before-write), leaving control in line_delay.

Verification
REQ-031 Defaults, reset, 23 consecutive accepts of 1..23 -> out_valid never 1; primed=1 after 23rd; fill_count=23.
REQ-032 Continue accepts 24..60 back-to-back -> data_out sequence 1..37, one cycle after each accept, out_valid=1 each cycle.
REQ-033 Random in_valid gaps (~50%) over 200 samples -> output sequence equals input delayed by 23 accepts; out_valid=0 on idle-following cycles, data_out held.
REQ-034 clear with in_valid=1 mid-RUN -> sample dropped, primed=0 next cycle; 23 new accepts needed before next out_valid.
REQ-035 Async reset pulse between clock edges mid-RUN -> all outputs 0 immediately; refill behaves as REQ-031.
REQ-036 DATA_WIDTH=8, IMAGE_WIDTH=10, KERNEL_WIDTH=3 (DEPTH=7), inputs -128,127,-1 repeating -> bit-exact output delayed 7 accepts across pointer wrap.
